// File: rtl/seqdet_sched_if.sv
// seqdet_sched_if: requester, detector and result signals of seqdet_sched.
// master = stimulus/detector side, slave = the scheduler.
interface seqdet_sched_if #(
  parameter int W  = 42,
  parameter int CW = 6
) ();
  logic          req0_valid;
  logic [W-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_data;
  logic          req1_ready;
  logic          det_rst;
  logic          det_x;
  logic          det_z;
  logic          res_valid;
  logic          res_id;
  logic [CW-1:0] res_count;
  logic          busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, det_z,
    input  req0_ready, req1_ready, det_rst, det_x,
    input  res_valid, res_id, res_count, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, det_z,
    output req0_ready, req1_ready, det_rst, det_x,
    output res_valid, res_id, res_count, busy
  );
endinterface

// File: rtl/seqdet_sched.sv
// seqdet_sched: round-robin two-requester scheduler feeding one serial
// sequence detector. Clears the detector, shifts the frame MSB-first,
// counts det_z hits (saturating) and reports the count with the requester id.
// Optional macro SEQDET_SCHED_REGZ_EN: detector z is registered, so a DRAIN
// cycle is added after SHIFT to catch the hit of the last bit.
module seqdet_sched #(
  parameter int W  = 42,
  parameter int CW = 6
) (
  input  logic             clk,
  input  logic             rst,
  seqdet_sched_if.slave    bus
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [CW-1:0]   hit_q, hit_d;
  logic            det_rst_q, det_rst_d;
  logic            det_x_q, det_x_d;
  logic            res_valid_q, res_valid_d;
  logic            res_id_q, res_id_d;
  logic [CW-1:0]   res_count_q, res_count_d;

  logic            gnt0, gnt1, idle;
  logic [CW-1:0]   hit_inc;

  // Arbitration: sole valid requester wins; on a tie the one not served last.
  assign idle = (state_q == IDLE);
  assign gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;

  // Saturating hit increment; holds at all-ones instead of wrapping.
  assign hit_inc = (bus.det_z && !(&hit_q)) ? hit_q + CW'(1) : hit_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      sh_q        <= '0;
      bcnt_q      <= '0;
      hit_q       <= '0;
      det_rst_q   <= 1'b0;
      det_x_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      sh_q        <= sh_d;
      bcnt_q      <= bcnt_d;
      hit_q       <= hit_d;
      det_rst_q   <= det_rst_d;
      det_x_q     <= det_x_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
    end
  end

  // Next state; the registered outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    sh_d        = sh_q;
    bcnt_d      = bcnt_q;
    hit_d       = hit_q;
    det_rst_d   = 1'b0;
    det_x_d     = 1'b0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req0_ready) begin
          sh_d      = bus.req0_data;
          id_d      = 1'b0;
          state_d   = CLEAR;
          det_rst_d = 1'b1;
        end else if (bus.req1_valid && bus.req1_ready) begin
          sh_d      = bus.req1_data;
          id_d      = 1'b1;
          state_d   = CLEAR;
          det_rst_d = 1'b1;
        end
      end
      CLEAR: begin
        hit_d   = '0;
        bcnt_d  = BW'(W - 1);
        det_x_d = sh_q[W-1];
        sh_d    = sh_q << 1;
        state_d = SHIFT;
      end
      SHIFT: begin
        hit_d = hit_inc;
        if (bcnt_q == '0) begin
`ifdef SEQDET_SCHED_REGZ_EN
          state_d     = DRAIN;
`else
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_count_d = hit_inc;
`endif
        end else begin
          bcnt_d  = bcnt_q - BW'(1);
          det_x_d = sh_q[W-1];
          sh_d    = sh_q << 1;
        end
      end
      DRAIN: begin
        hit_d       = hit_inc;
        state_d     = REPORT;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        res_count_d = hit_inc;
      end
      REPORT: begin
        last_d  = res_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.det_rst   = det_rst_q;
  assign bus.det_x     = det_x_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_count = res_count_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_seqdet_sched.sv
// tb_seqdet_sched: directed bench for seqdet_sched (W=8) with an
// overlapping "11" detector model; second instance uses CW=2 for saturation.
module tb_seqdet_sched;
`ifdef SEQDET_SCHED_REGZ_EN
  localparam int LAT = 11;
  localparam int PER = 12;
`else
  localparam int LAT = 10;
  localparam int PER = 11;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seqdet_sched_if #(.W(8), .CW(4)) m ();
  seqdet_sched_if #(.W(8), .CW(2)) s ();

  seqdet_sched #(.W(8), .CW(4)) dut   (.clk(clk), .rst(rst), .bus(m));
  seqdet_sched #(.W(8), .CW(2)) dut_s (.clk(clk), .rst(rst), .bus(s));

  // Detector models: z = x & prev_x, cleared by det_rst.
  logic m_prev, m_zr, s_prev, s_zr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev <= 1'b0; m_zr <= 1'b0; s_prev <= 1'b0; s_zr <= 1'b0;
    end else begin
      m_prev <= m.det_rst ? 1'b0 : m.det_x;
      m_zr   <= m.det_rst ? 1'b0 : (m.det_x & m_prev);
      s_prev <= s.det_rst ? 1'b0 : s.det_x;
      s_zr   <= s.det_rst ? 1'b0 : (s.det_x & s_prev);
    end
  end
`ifdef SEQDET_SCHED_REGZ_EN
  assign m.det_z = m_zr;
  assign s.det_z = s_zr;
`else
  assign m.det_z = m.det_x & m_prev;
  assign s.det_z = s.det_x & s_prev;
`endif

  // Negedge monitor of the main instance.
  int   ncyc = 0;
  logic xlog [0:4095];
  logic rlog [0:4095];
  int   hs_cyc[$];
  int   hs_id[$];
  int   r_cyc[$];
  int   r_id[$];
  int   r_cnt[$];
  bit   r0_seen = 1'b0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    xlog[ncyc % 4096] = m.det_x;
    rlog[ncyc % 4096] = m.det_rst;
    if (m.req0_valid && m.req0_ready) begin hs_cyc.push_back(ncyc); hs_id.push_back(0); end
    if (m.req1_valid && m.req1_ready) begin hs_cyc.push_back(ncyc); hs_id.push_back(1); end
    if (m.res_valid) begin
      r_cyc.push_back(ncyc); r_id.push_back(int'(m.res_id)); r_cnt.push_back(int'(m.res_count));
    end
    if (m.req0_ready) r0_seen = 1'b1;
  end

  task automatic clear_logs();
    hs_cyc.delete(); hs_id.delete(); r_cyc.delete(); r_id.delete(); r_cnt.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m.req0_valid = 1'b0; m.req1_valid = 1'b0;
    s.req0_valid = 1'b0; s.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  // Present one frame on the main instance and hold it until accepted.
  task automatic send(input int id, input logic [7:0] d, output bit ok);
    int n = 0;
    @(posedge clk); #1;
    if (id == 0) begin m.req0_valid = 1'b1; m.req0_data = d; end
    else         begin m.req1_valid = 1'b1; m.req1_data = d; end
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(negedge clk);
      ok = (id == 0) ? m.req0_ready : m.req1_ready;
      n++;
    end
    @(posedge clk); #1;
    if (id == 0) m.req0_valid = 1'b0; else m.req1_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout id=%0d got=no_ready want=ready", id);
    end
  endtask

  task automatic wait_res(input int idx, output bit ok);
    int n = 0;
    while (n < 100 && r_cyc.size() <= idx) begin
      @(negedge clk); #1; n++;
    end
    ok = (r_cyc.size() > idx);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL result_timeout idx=%0d got=%0d results want=%0d", idx, r_cyc.size(), idx + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m.req0_valid = 1'b1; m.req1_valid = 1'b1;
    m.req0_data = 8'h00; m.req1_data = 8'h00;
    s.req0_valid = 1'b0; s.req1_valid = 1'b0;
    s.req0_data = 8'h00; s.req1_data = 8'h00;
    @(negedge clk); #1;
    total++; if (m.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", m.busy); end
    total++; if (m.det_x !== 1'b0)     begin bad++; $display("FAIL rst_det_x got=%b want=0", m.det_x); end
    total++; if (m.det_rst !== 1'b0)   begin bad++; $display("FAIL rst_det_rst got=%b want=0", m.det_rst); end
    total++; if (m.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", m.res_valid); end
    total++; if (m.res_id !== 1'b0)    begin bad++; $display("FAIL rst_res_id got=%b want=0", m.res_id); end
    total++; if (m.res_count !== 4'd0) begin bad++; $display("FAIL rst_res_count got=%0d want=0", m.res_count); end
    total++; if (m.req0_ready !== 1'b1 || m.req1_ready !== 1'b0) begin
      bad++; $display("FAIL rst_first_grant got=%b%b want=10", m.req0_ready, m.req1_ready);
    end
    m.req0_valid = 1'b0; m.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int t; logic [7:0] xb;
    do_reset();
    send(0, 8'hF0, ok);
    wait_res(0, ok);
    if (!ok) return;
    t = hs_cyc[0];
    for (int k = 0; k < 8; k++) xb[7-k] = xlog[(t + 2 + k) % 4096];
    total++; if (r_id[0] !== 0)         begin bad++; $display("FAIL basic_id got=%0d want=0", r_id[0]); end
    total++; if (r_cnt[0] !== 3)        begin bad++; $display("FAIL basic_count got=%0d want=3", r_cnt[0]); end
    total++; if (r_cyc[0] - t !== LAT)  begin bad++; $display("FAIL basic_latency got=%0d want=%0d", r_cyc[0] - t, LAT); end
    total++; if (rlog[(t + 1) % 4096] !== 1'b1) begin bad++; $display("FAIL basic_det_rst got=%b want=1", rlog[(t + 1) % 4096]); end
    total++; if (xb !== 8'hF0)          begin bad++; $display("FAIL basic_det_x_seq got=%h want=f0", xb); end
    total++; if (xlog[(t + 1) % 4096] !== 1'b0 || xlog[(t + 10) % 4096] !== 1'b0) begin
      bad++; $display("FAIL basic_det_x_idle got=%b%b want=00", xlog[(t + 1) % 4096], xlog[(t + 10) % 4096]);
    end
  endtask

  task automatic test_round_robin();
    bit ok_a, ok_b, ok;
    do_reset();
    fork
      send(0, 8'hAA, ok_a);
      send(1, 8'hFF, ok_b);
    join
    wait_res(1, ok);
    if (!ok) return;
    total++; if (r_id[0] !== 0 || r_cnt[0] !== 0) begin bad++; $display("FAIL rr_first got=id%0d/cnt%0d want=id0/cnt0", r_id[0], r_cnt[0]); end
    total++; if (r_id[1] !== 1 || r_cnt[1] !== 7) begin bad++; $display("FAIL rr_second got=id%0d/cnt%0d want=id1/cnt7", r_id[1], r_cnt[1]); end
    fork
      send(0, 8'h0F, ok_a);
      send(1, 8'h0F, ok_b);
    join
    wait_res(3, ok);
    if (!ok) return;
    total++; if (hs_id[2] !== 0 || hs_id[3] !== 1) begin bad++; $display("FAIL rr_alternate got=%0d,%0d want=0,1", hs_id[2], hs_id[3]); end
    total++; if (r_cnt[2] !== 3)  begin bad++; $display("FAIL rr_count_0f got=%0d want=3", r_cnt[2]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    r0_seen = 1'b0;
    repeat (3) send(1, 8'hFF, ok);
    wait_res(2, ok);
    if (!ok) return;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_id[i] !== 1 || r_cnt[i] !== 7) begin
        bad++; $display("FAIL b2b_result%0d got=id%0d/cnt%0d want=id1/cnt7", i, r_id[i], r_cnt[i]);
      end
    end
    total++; if (hs_cyc[1] - hs_cyc[0] !== PER || hs_cyc[2] - hs_cyc[1] !== PER) begin
      bad++; $display("FAIL b2b_spacing got=%0d,%0d want=%0d", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1], PER);
    end
    total++; if (r0_seen !== 1'b0) begin bad++; $display("FAIL b2b_req0_ready got=1 want=0"); end
  endtask

  task automatic test_saturation();
    bit ok = 1'b0; int n = 0;
    do_reset();
    @(posedge clk); #1;
    s.req0_valid = 1'b1; s.req0_data = 8'hFF;
    while (n < 100 && !ok) begin @(negedge clk); ok = s.req0_ready; n++; end
    @(posedge clk); #1;
    s.req0_valid = 1'b0;
    n = 0;
    while (n < 100 && s.res_valid !== 1'b1) begin @(negedge clk); n++; end
    total++;
    if (s.res_valid !== 1'b1) begin
      bad++; $display("FAIL sat_timeout got=no_result want=result");
    end else if (s.res_count !== 2'd3 || s.res_id !== 1'b0) begin
      bad++; $display("FAIL sat_count got=id%0d/cnt%0d want=id0/cnt3", s.res_id, s.res_count);
    end
  endtask

  task automatic test_mid_reset();
    bit ok; int t; int n = 0;
    do_reset();
    send(0, 8'hF0, ok);
    if (!ok) return;
    t = hs_cyc[0];
    // Stop in the SHIFT cycle carrying frame bit 4 (a 1 for 8'hF0).
    while (n < 50 && ncyc != t + 5) begin @(negedge clk); #1; n++; end
    total++; if (m.busy !== 1'b1 || m.det_x !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=busy%b/x%b want=busy1/x1", m.busy, m.det_x);
    end
    rst = 1'b1;
    #1;
    total++; if (m.busy !== 1'b0 || m.det_x !== 1'b0 || m.res_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_clear got=busy%b/x%b/v%b want=000", m.busy, m.det_x, m.res_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++; if (r_cyc.size() !== 0) begin bad++; $display("FAIL midrst_no_result got=%0d want=0", r_cyc.size()); end
    send(0, 8'hF0, ok);
    wait_res(0, ok);
    if (!ok) return;
    total++; if (r_id[0] !== 0 || r_cnt[0] !== 3) begin
      bad++; $display("FAIL midrst_resend got=id%0d/cnt%0d want=id0/cnt3", r_id[0], r_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
